// File: rtl/fft_result_reader.sv
// Captures FFT output frames into a ping-pong buffer and streams them back in
// bin order with |X|^2 per bin, tracking the peak bin of every frame read out.
module fft_result_reader #(
    parameter int width = 16,
    parameter int NALL  = 9,
    parameter int DROPW = 8
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    fft_en,
    input  logic [NALL-1:0]         fft_cnt,
    input  logic signed [width-1:0] fft_re,
    input  logic signed [width-1:0] fft_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NALL-1:0]         out_idx,
    output logic signed [width-1:0] out_re,
    output logic signed [width-1:0] out_im,
    output logic [2*width:0]        out_pow,
    output logic                    out_last,
    output logic                    peak_valid,
    output logic [NALL-1:0]         peak_idx,
    output logic [2*width:0]        peak_pow,
    output logic [DROPW-1:0]        drop_cnt
);

    localparam int DEPTH = 1 << NALL;
    localparam logic [NALL-1:0] LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic               r_sync;
    logic               r_wok;
    logic               r_wbank;
    logic [1:0]         r_full;
    logic               r_rbank;
    logic [NALL-1:0]    r_ridx;
    logic               r_issued_all;
    logic               r_s1_valid;
    logic [NALL-1:0]    r_s1_idx;
    logic [2*width-1:0] r_rd_data;
    logic [2*width:0]   r_max_pow;
    logic [NALL-1:0]    r_max_idx;
    logic [2*width-1:0] r_mem [0:2*DEPTH-1];

    logic w_start, w_active, w_bank_free, w_ok, w_we;
    logic w_complete, w_keep, w_drop, w_free_rbank;
    logic [1:0] w_set_mask, w_clr_mask, w_avail;
    logic w_adv, w_hs, w_rd_en, w_enter_read;
    logic signed [width-1:0]   w_s1_re, w_s1_im;
    logic signed [2*width-1:0] w_re_ext, w_im_ext, w_sq_re, w_sq_im;
    logic [2*width:0]          w_pow, w_max_pow_n;
    logic [NALL-1:0]           w_max_idx_n;

    // A frame may only be captured if its bank was free when bin 0 arrived;
    // a bank released by the reader in that same cycle counts as free.
    assign w_free_rbank = (r_state == S_DONE);
    assign w_start      = fft_en && (fft_cnt == '0);
    assign w_active     = fft_en && (r_sync || w_start);
    assign w_bank_free  = !r_full[r_wbank] || (w_free_rbank && (r_rbank == r_wbank));
    assign w_ok         = w_start ? w_bank_free : r_wok;
    assign w_we         = w_active && w_ok;
    assign w_complete   = w_active && (fft_cnt == LAST);
    assign w_keep       = w_complete && w_ok;
    assign w_drop       = w_complete && !w_ok;
    assign w_set_mask   = {r_wbank, !r_wbank} & {2{w_keep}};
    assign w_clr_mask   = {r_rbank, !r_rbank} & {2{w_free_rbank}};
    assign w_avail      = r_full | w_set_mask;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_sync   <= 1'b0;
            r_wok    <= 1'b0;
            r_wbank  <= 1'b0;
            r_full   <= 2'b00;
            drop_cnt <= '0;
        end else begin
            if (w_start)
                r_sync <= 1'b1;
            if (w_active)
                r_wok <= w_ok && !w_complete;
            if (w_keep)
                r_wbank <= !r_wbank;
            if (w_drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
            r_full <= (r_full & ~w_clr_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[{r_wbank, fft_cnt}] <= {fft_re, fft_im};
    end

    assign w_adv   = !out_valid || out_ready;
    assign w_hs    = out_valid && out_ready;
    assign w_rd_en = (r_state == S_READ) && w_adv && !r_issued_all;

    always_ff @(posedge clk) begin
        if (w_rd_en)
            r_rd_data <= r_mem[{r_rbank, r_ridx}];
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_enter_read = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_avail) begin
                    w_state_next = S_READ;
                    w_enter_read = 1'b1;
                end
            end
            S_READ: begin
                if (w_hs && out_last)
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Products are at most 2**(2*width-2) each, so the extra sum bit never overflows.
    assign w_s1_re  = r_rd_data[2*width-1:width];
    assign w_s1_im  = r_rd_data[width-1:0];
    assign w_re_ext = {{width{w_s1_re[width-1]}}, w_s1_re};
    assign w_im_ext = {{width{w_s1_im[width-1]}}, w_s1_im};
    assign w_sq_re  = w_re_ext * w_re_ext;
    assign w_sq_im  = w_im_ext * w_im_ext;
    assign w_pow    = {1'b0, w_sq_re} + {1'b0, w_sq_im};

    assign w_max_pow_n = (out_pow > r_max_pow) ? out_pow : r_max_pow;
    assign w_max_idx_n = (out_pow > r_max_pow) ? out_idx : r_max_idx;

    // Address issue, RAM register and output register move together as one
    // rigid pipeline, so a stall freezes every stage in place.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_rbank      <= 1'b0;
            r_ridx       <= '0;
            r_issued_all <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_idx     <= '0;
            r_max_pow    <= '0;
            r_max_idx    <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_idx      <= '0;
            out_re       <= '0;
            out_im       <= '0;
            out_pow      <= '0;
            peak_valid   <= 1'b0;
            peak_idx     <= '0;
            peak_pow     <= '0;
        end else begin
            peak_valid <= w_hs && out_last;
            if (w_enter_read) begin
                r_rbank      <= !w_avail[0];
                r_ridx       <= '0;
                r_issued_all <= 1'b0;
                r_s1_valid   <= 1'b0;
                r_max_pow    <= '0;
                r_max_idx    <= '0;
            end else if ((r_state == S_READ) && w_adv) begin
                r_s1_valid <= !r_issued_all;
                if (!r_issued_all) begin
                    r_s1_idx     <= r_ridx;
                    r_ridx       <= r_ridx + 1'b1;
                    r_issued_all <= (r_ridx == LAST);
                end
            end
            if (w_adv) begin
                out_valid <= r_s1_valid;
                out_last  <= r_s1_valid && (r_s1_idx == LAST);
                if (r_s1_valid) begin
                    out_idx <= r_s1_idx;
                    out_re  <= w_s1_re;
                    out_im  <= w_s1_im;
                    out_pow <= w_pow;
                end
            end
            if (w_hs) begin
                r_max_pow <= w_max_pow_n;
                r_max_idx <= w_max_idx_n;
                if (out_last) begin
                    peak_pow <= w_max_pow_n;
                    peak_idx <= w_max_idx_n;
                end
            end
        end
    end

endmodule
